// File: rtl/gen_scheduler.sv
// gen_scheduler: round-robin time-sharing of one output stream across N_GEN
// generator instances. One generator runs at a time. Its tuples pass through a
// single-entry output register with valid/ready handshaking. A watchdog ends
// jobs that stop making progress.
module gen_scheduler #(
  parameter int N_GEN   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024,
  localparam int IDW    = (N_GEN > 2) ? $clog2(N_GEN) : 1
) (
  input  logic                   _clock,
  input  logic                   _reset_n,
  input  logic [N_GEN-1:0]       req,
  output logic [N_GEN-1:0]       gen_start,
  output logic [N_GEN-1:0]       gen_ready,
  input  logic [N_GEN-1:0]       gen_valid,
  input  logic [N_GEN-1:0]       gen_done,
  input  logic [N_GEN*WIDTH-1:0] gen_out0,
  input  logic [N_GEN*WIDTH-1:0] gen_out1,
  output logic [WIDTH-1:0]       _out0,
  output logic [WIDTH-1:0]       _out1,
  output logic [IDW-1:0]         _src,
  output logic                   _valid,
  input  logic                   _ready,
  output logic                   busy,
  output logic                   job_done,
  output logic [IDW-1:0]         job_id,
  output logic                   job_err
);

  // Watchdog counter wide enough to hold TIMEOUT itself.
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDW:0]       N_GEN_W  = (IDW + 1)'(N_GEN);
  localparam logic [IDW-1:0]     LAST_IDX = IDW'(N_GEN - 1);
  localparam logic [N_GEN-1:0]   ONE_HOT0 = N_GEN'(1);
  localparam logic [WDW-1:0]     TMO_W    = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Registered state
  state_t             r_state;
  logic [IDW-1:0]     r_grant;
  logic [IDW-1:0]     r_ptr;
  logic [WDW-1:0]     r_wdog;
  logic               r_err;
  logic               r_valid;
  logic [WIDTH-1:0]   r_out0;
  logic [WIDTH-1:0]   r_out1;
  logic [IDW-1:0]     r_src;
  logic [N_GEN-1:0]   r_gen_start;

  // Combinational helpers
  logic [2*N_GEN-1:0] w_req_rot;
  logic [IDW-1:0]     w_off;
  logic [IDW:0]       w_pick_sum;
  logic [IDW:0]       w_pick_wrap;
  logic [IDW-1:0]     w_pick;
  logic [IDW-1:0]     w_next_ptr;
  logic               w_in_run;
  logic               w_ready_g;
  logic               w_valid_g;
  logic               w_done_g;
  logic               w_gen_xfer;
  logic               w_out_xfer;
  logic               w_wdog_tick;
  logic [WDW-1:0]     w_wdog_inc;
  logic               w_timeout_hit;
  logic [WIDTH-1:0]   w_slice0;
  logic [WIDTH-1:0]   w_slice1;

  // Rotate requests so bit 0 is the requester at ptr; the first set bit is the
  // offset of the winner from ptr, which gives wrap-around priority for free.
  assign w_req_rot = {req, req} >> r_ptr;

  // Lowest set bit of the rotated request vector (offset from ptr).
  always_comb begin
    w_off = '0;
    for (int k = N_GEN - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_off = IDW'(k);
      end
    end
  end

  assign w_pick_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_pick_wrap = (w_pick_sum >= N_GEN_W) ? (w_pick_sum - N_GEN_W) : w_pick_sum;
  assign w_pick      = w_pick_wrap[IDW-1:0];
  assign w_next_ptr  = (r_grant == LAST_IDX) ? '0 : (r_grant + 1'b1);

  // Signals of the currently granted generator.
  assign w_valid_g = gen_valid[r_grant];
  assign w_done_g  = gen_done[r_grant];
  assign w_slice0  = gen_out0[r_grant*WIDTH +: WIDTH];
  assign w_slice1  = gen_out1[r_grant*WIDTH +: WIDTH];

  // The output register can take a new tuple when empty or draining this cycle.
  assign w_in_run   = (r_state == S_RUN);
  assign w_ready_g  = !r_valid || _ready;
  assign w_gen_xfer = w_in_run && w_ready_g && w_valid_g;
  assign w_out_xfer = r_valid && _ready;

  // The watchdog only counts cycles where the generator is the one holding
  // things up; a downstream stall is not the generator's fault.
  assign w_wdog_tick   = w_in_run && w_ready_g && !w_valid_g && !w_done_g;
  assign w_wdog_inc    = r_wdog + 1'b1;
  assign w_timeout_hit = (TIMEOUT != 0) && (w_wdog_inc == TMO_W);

  // Only the granted generator sees ready, and only while running.
  for (genvar gi = 0; gi < N_GEN; gi++) begin : g_ready
    assign gen_ready[gi] = w_in_run && w_ready_g && (r_grant == IDW'(gi));
  end

  assign gen_start = r_gen_start;
  assign _out0     = r_out0;
  assign _out1     = r_out1;
  assign _src      = r_src;
  assign _valid    = r_valid;
  assign busy      = (r_state != S_IDLE);
  // Job completion is reported in the FINISH cycle in which the output has drained.
  assign job_done  = (r_state == S_FINISH) && !r_valid;
  assign job_id    = job_done ? r_grant : '0;
  assign job_err   = job_done && r_err;

  // Scheduler FSM together with the output register and watchdog.
  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_wdog      <= '0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_src       <= '0;
      r_gen_start <= '0;
    end else begin
      r_gen_start <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant     <= w_pick;
            r_gen_start <= ONE_HOT0 << w_pick;
            r_state     <= S_START;
          end
        end

        S_START: begin
          r_wdog  <= '0;
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (w_gen_xfer) begin
            r_out0  <= w_slice0;
            r_out1  <= w_slice1;
            r_src   <= r_grant;
            r_valid <= 1'b1;
          end else if (w_out_xfer) begin
            r_valid <= 1'b0;
          end

          if (w_gen_xfer) begin
            r_wdog <= '0;
          end else if (w_wdog_tick) begin
            r_wdog <= w_wdog_inc;
          end

          // A done generator wins over a simultaneous timeout.
          if (w_done_g) begin
            r_state <= S_FINISH;
          end else if (w_wdog_tick && w_timeout_hit) begin
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          if (r_valid) begin
            if (_ready) begin
              r_valid <= 1'b0;
            end
          end else begin
            r_ptr   <= w_next_ptr;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gen_scheduler.sv
// tb_gen_scheduler: directed vector table plus hand-written multi-cycle
// sequences for gen_scheduler (N_GEN=4, WIDTH=32, TIMEOUT=8).
module tb_gen_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   gen_start;
  logic [3:0]   gen_ready;
  logic [3:0]   gen_valid;
  logic [3:0]   gen_done;
  logic [127:0] gen_out0;
  logic [127:0] gen_out1;
  logic [31:0]  out0;
  logic [31:0]  out1;
  logic [1:0]   src;
  logic         valid;
  logic         ready;
  logic         busy;
  logic         job_done;
  logic [1:0]   job_id;
  logic         job_err;

  int n_checks;
  int n_fail;

  gen_scheduler #(.N_GEN(4), .WIDTH(32), .TIMEOUT(8)) dut (
    ._clock   (clk),
    ._reset_n (rst_n),
    .req      (req),
    .gen_start(gen_start),
    .gen_ready(gen_ready),
    .gen_valid(gen_valid),
    .gen_done (gen_done),
    .gen_out0 (gen_out0),
    .gen_out1 (gen_out1),
    ._out0    (out0),
    ._out1    (out1),
    ._src     (src),
    ._valid   (valid),
    ._ready   (ready),
    .busy     (busy),
    .job_done (job_done),
    .job_id   (job_id),
    .job_err  (job_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gv;
    logic [3:0]  gd;
    int          slot;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic [3:0]  e_start;
    logic [3:0]  e_gready;
    logic        e_valid;
    logic [31:0] e_o0;
    logic [31:0] e_o1;
    logic [1:0]  e_src;
    logic        e_busy;
    logic        e_done;
    logic [1:0]  e_id;
    logic        e_err;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [3:0] r, input logic [3:0] gv, input logic [3:0] gd, input int slot,
    input logic [31:0] d0, input logic [31:0] d1, input logic rdy,
    input logic [3:0] e_start, input logic [3:0] e_gready, input logic e_valid,
    input logic [31:0] e_o0, input logic [31:0] e_o1, input logic [1:0] e_src,
    input logic e_busy, input logic e_done, input logic [1:0] e_id, input logic e_err);
    vec_t v;
    v.req = r; v.gv = gv; v.gd = gd; v.slot = slot; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.e_start = e_start; v.e_gready = e_gready; v.e_valid = e_valid;
    v.e_o0 = e_o0; v.e_o1 = e_o1; v.e_src = e_src;
    v.e_busy = e_busy; v.e_done = e_done; v.e_id = e_id; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Only the selected slot carries the tuple; the others carry marker values
  // so a wrong slice selection shows up as a data error.
  task automatic drive(input logic [3:0] r, input logic [3:0] gv, input logic [3:0] gd,
                       input int slot, input logic [31:0] d0, input logic [31:0] d1,
                       input logic rdy);
    req       = r;
    gen_valid = gv;
    gen_done  = gd;
    ready     = rdy;
    for (int i = 0; i < 4; i++) begin
      gen_out0[i*32 +: 32] = (i == slot) ? d0 : (32'hA5A5_0000 + 32'(i));
      gen_out1[i*32 +: 32] = (i == slot) ? d1 : (32'h5A5A_0000 + 32'(i));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(gen_start), 32'd0);
    check({tag, "_gready"}, 32'(gen_ready), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_out0"}, out0, 32'd0);
    check({tag, "_out1"}, out1, 32'd0);
    check({tag, "_src"}, 32'(src), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(job_done), 32'd0);
    check({tag, "_id"}, 32'(job_id), 32'd0);
    check({tag, "_err"}, 32'(job_err), 32'd0);
  endtask

  // Hard stop if the run ever wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

  initial begin
    int cnt;
    int g;
    logic [3:0] exp_oh;

    n_checks = 0;
    n_fail   = 0;

    // Single job on gen 0: (1,2),(3,4) then done
    vecs[0]  = mk(4'b0001, 0, 0, 0, 0, 0, 1,  4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1,        4'b0001, 0, 0, 0, 0, 0,        1, 0, 0, 0);
    vecs[2]  = mk(0, 4'b0001, 0, 0, 1, 2, 1,  0, 4'b0001, 0, 0, 0, 0,        1, 0, 0, 0);
    vecs[3]  = mk(0, 4'b0001, 0, 0, 3, 4, 1,  0, 4'b0001, 1, 1, 2, 0,        1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 4'b0001, 0, 0, 0, 1,  0, 4'b0001, 1, 3, 4, 0,        1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 4'b0001, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0,              1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0, 0,              0, 0, 0, 0);
    // Gen 1: valid and done together with (7,-7)
    vecs[7]  = mk(4'b0010, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0,              0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 0, 1,        4'b0010, 0, 0, 0, 0, 0,        1, 0, 0, 0);
    vecs[9]  = mk(0, 4'b0010, 4'b0010, 1, 7, -7, 1, 0, 4'b0010, 0, 0, 0, 0,  1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 0, 1,        0, 0, 1, 7, -7, 1,             1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 0, 0, 1,        0, 0, 0, 0, 0, 0,              1, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 1,        0, 0, 0, 0, 0, 0,              0, 0, 0, 0);
    // Gen 2: four tuples under backpressure, ready pattern 1,0,0,1
    vecs[13] = mk(4'b0100, 0, 0, 2, 0, 0, 1,  0, 0, 0, 0, 0, 0,              0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 2, 0, 0, 1,        4'b0100, 0, 0, 0, 0, 0,        1, 0, 0, 0);
    vecs[15] = mk(0, 4'b0100, 0, 2, 10, 11, 1, 0, 4'b0100, 0, 0, 0, 0,       1, 0, 0, 0);
    vecs[16] = mk(0, 4'b0100, 0, 2, 20, 21, 0, 0, 0, 1, 10, 11, 2,           1, 0, 0, 0);
    vecs[17] = mk(0, 4'b0100, 0, 2, 20, 21, 0, 0, 0, 1, 10, 11, 2,           1, 0, 0, 0);
    vecs[18] = mk(0, 4'b0100, 0, 2, 20, 21, 1, 0, 4'b0100, 1, 10, 11, 2,     1, 0, 0, 0);
    vecs[19] = mk(0, 4'b0100, 0, 2, 30, 31, 1, 0, 4'b0100, 1, 20, 21, 2,     1, 0, 0, 0);
    vecs[20] = mk(0, 4'b0100, 0, 2, 40, 41, 0, 0, 0, 1, 30, 31, 2,           1, 0, 0, 0);
    vecs[21] = mk(0, 4'b0100, 0, 2, 40, 41, 0, 0, 0, 1, 30, 31, 2,           1, 0, 0, 0);
    vecs[22] = mk(0, 4'b0100, 0, 2, 40, 41, 1, 0, 4'b0100, 1, 30, 31, 2,     1, 0, 0, 0);
    vecs[23] = mk(0, 0, 4'b0100, 2, 0, 0, 0,  0, 0, 1, 40, 41, 2,            1, 0, 0, 0);
    vecs[24] = mk(0, 0, 4'b0100, 2, 0, 0, 0,  0, 0, 1, 40, 41, 2,            1, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 2, 0, 0, 1,        0, 0, 1, 40, 41, 2,            1, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 2, 0, 0, 1,        0, 0, 0, 0, 0, 0,              1, 1, 2, 0);
    vecs[27] = mk(0, 0, 0, 2, 0, 0, 1,        0, 0, 0, 0, 0, 0,              0, 0, 0, 0);

    // Reset and reset-state check
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("reset");
    $display("reset: start=%b gready=%b valid=%b busy=%b done=%b", gen_start, gen_ready, valid, busy, job_done);

    // Vector table
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      drive(vecs[v].req, vecs[v].gv, vecs[v].gd, vecs[v].slot, vecs[v].d0, vecs[v].d1, vecs[v].rdy);
      #1;
      check($sformatf("vec%0d_start", v), 32'(gen_start), 32'(vecs[v].e_start));
      check($sformatf("vec%0d_gready", v), 32'(gen_ready), 32'(vecs[v].e_gready));
      check($sformatf("vec%0d_valid", v), 32'(valid), 32'(vecs[v].e_valid));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
      check($sformatf("vec%0d_done", v), 32'(job_done), 32'(vecs[v].e_done));
      if (vecs[v].e_valid) begin
        check($sformatf("vec%0d_out0", v), out0, vecs[v].e_o0);
        check($sformatf("vec%0d_out1", v), out1, vecs[v].e_o1);
        check($sformatf("vec%0d_src", v), 32'(src), 32'(vecs[v].e_src));
      end
      if (vecs[v].e_done) begin
        check($sformatf("vec%0d_id", v), 32'(job_id), 32'(vecs[v].e_id));
        check($sformatf("vec%0d_err", v), 32'(job_err), 32'(vecs[v].e_err));
      end
      $display("vec %0d: start=%b gready=%b valid=%b out=(%0d,%0d) src=%0d busy=%b done=%b id=%0d err=%b",
               v, gen_start, gen_ready, valid, $signed(out0), $signed(out1), src, busy, job_done, job_id, job_err);
    end

    // Timeout: ptr is 3, req=1001 grants gen 3, which never responds
    @(negedge clk);
    drive(4'b1001, 0, 0, 3, 0, 0, 1);
    #1;
    check("to_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("to_start", 32'(gen_start), 32'b1000);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      if (job_done) begin
        cnt = k;
        break;
      end
    end
    check("to_latency", 32'(cnt), 32'd9);
    check("to_err", 32'(job_err), 32'd1);
    check("to_id", 32'(job_id), 32'd3);
    $display("timeout job: done after %0d cycles, id=%0d err=%b", cnt, job_id, job_err);
    @(negedge clk);
    #1;
    check("to_then_idle", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("to_next_grant", 32'(gen_start), 32'b0001);

    // Reset mid-job with a tuple held in the output register
    @(negedge clk);
    drive(0, 4'b0001, 0, 0, 55, 66, 0);
    #1;
    check("rst_gready", 32'(gen_ready), 32'b0001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_pending_valid", 32'(valid), 32'd1);
    check("rst_pending_out0", out0, 32'd55);
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0010, 0, 0, 1, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    #1;
    check("rst_regrant", 32'(gen_start), 32'b0010);
    check("rst_no_done", 32'(job_done), 32'd0);
    @(negedge clk);
    drive(0, 0, 4'b0010, 1, 0, 0, 1);
    #1;
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 1);
    #1;
    check("rst_job1_done", 32'(job_done), 32'd1);
    check("rst_job1_id", 32'(job_id), 32'd1);
    $display("reset mid-job: regrant gen1, job_done=%b id=%0d", job_done, job_id);

    // Round-robin from a fresh reset with all four requesting
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 0, 0, 0, 0, 0, 1);
    for (int j = 0; j < 5; j++) begin
      g = j % 4;
      exp_oh = 4'b0001 << g;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        drive(4'b1111, 0, 0, g, 0, 0, 1);
        #1;
        if (gen_start != 4'b0000) break;
      end
      check($sformatf("rr%0d_start", j), 32'(gen_start), 32'(exp_oh));
      @(negedge clk);
      drive(4'b1111, exp_oh, exp_oh, g, 32'(100 + j), -32'(j), 1);
      #1;
      check($sformatf("rr%0d_gready", j), 32'(gen_ready), 32'(exp_oh));
      @(negedge clk);
      drive(4'b1111, 0, 0, g, 0, 0, 1);
      #1;
      check($sformatf("rr%0d_valid", j), 32'(valid), 32'd1);
      check($sformatf("rr%0d_out0", j), out0, 32'(100 + j));
      check($sformatf("rr%0d_out1", j), out1, -32'(j));
      check($sformatf("rr%0d_src", j), 32'(src), 32'(g));
      @(negedge clk);
      #1;
      check($sformatf("rr%0d_done", j), 32'(job_done), 32'd1);
      check($sformatf("rr%0d_id", j), 32'(job_id), 32'(g));
      $display("rr job %0d: expected gen %0d, start=%b out=(%0d,%0d) src=%0d done=%b id=%0d",
               j, g, exp_oh, $signed(out0), $signed(out1), src, job_done, job_id);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_scheduler.md
# gen_scheduler

Round-robin scheduler that time-shares one output stream between `N_GEN` generator instances produced by the Python-to-Verilog flow. It accepts per-generator run requests and starts one generator at a time with a one-cycle `_start` pulse. It forwards that generator's `(_out0, _out1)` tuples through a single-entry output register with valid/ready backpressure, and reports job completion or timeout. It sits between the generated generator modules and the downstream consumer/testbench harness.

## Interface
- `N_GEN`, default 4: number of attached generators, 2..16.
- `WIDTH`, default 32: signed width of each output field.
- `TIMEOUT`, default 1024: maximum no-progress cycles in RUN; 0 disables the watchdog.
- `IDW`: localparam, `max(1, clog2(N_GEN))`.

Ports:
- `_clock`  in  1  sole clock; all logic on the rising edge.
- `_reset_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_GEN  run request per generator; level, sampled only in IDLE.
- `gen_start`  out  N_GEN  one-hot, one-cycle start pulse to the granted generator.
- `gen_ready`  out  N_GEN  backpressure to the generators; only the granted bit can be high.
- `gen_valid`  in  N_GEN  generator i presents a tuple.
- `gen_done`  in  N_GEN  generator i has finished; level.
- `gen_out0`, `gen_out1`  in  N_GEN*WIDTH  packed tuples; generator i occupies `[i*WIDTH +: WIDTH]`.
- `_out0`, `_out1`  out  WIDTH  forwarded tuple.
- `_src`  out  IDW  index of the generator that produced `_out0`/`_out1`.
- `_valid`  out  1  output register full.
- `_ready`  in  1  downstream accepts.
- `busy`  out  1  state is not IDLE.
- `job_done`  out  1  one-cycle pulse at job end.
- `job_id`  out  IDW  generator index; valid while `job_done` is high.
- `job_err`  out  1  qualifies `job_done`: the job ended by timeout.

## Operation
FSM states are IDLE, START, RUN and FINISH.

- **IDLE:** if `req` is nonzero, select grant `g` = first set bit at or after `ptr` (wrapping), latch `g`, go to START. Otherwise stay.
- **START:** drive `gen_start[g]`=1 for exactly this cycle, clear the watchdog, go to RUN. `gen_done` is ignored in this state.
- **RUN:**
  - `gen_ready[g]` = `!_valid || _ready`.
  - Gen transfer = `gen_valid[g] && gen_ready[g]`. It loads `_out0`/`_out1` from slice `g`, sets `_src`=`g`, and sets `_valid`=1.
  - Out transfer = `_valid && _ready`. It clears `_valid` unless a gen transfer happens in the same cycle, in which case `_valid` stays 1 with the new data.
  - If `gen_done[g]` is high (any transfer that cycle still completes), go to FINISH.
  - Watchdog:
    - Increments when `gen_ready[g] && !gen_valid[g] && !gen_done[g]`.
    - Clears on a gen transfer.
    - Holds while downstream stalls.
    - On reaching `TIMEOUT` (if nonzero), go to FINISH with the error flag set.
- **FINISH:** wait until `_valid`=0, then pulse `job_done` with `job_id`=`g` and `job_err`=error flag. Set `ptr`=(`g`+1) mod `N_GEN`, clear the flag, go to IDLE.

Other rules:
- A `req` change after grant has no effect on the running job.
- `req[g]` still high in IDLE is re-served only after the other pending requesters.
- Data fields are passed unmodified; there is no arithmetic on data.

## Timing
- Reset (`_reset_n`=0 at an edge) forces:
  - State IDLE, `ptr`=0, watchdog=0.
  - All outputs 0: `gen_start`, `gen_ready`, `_out0`, `_out1`, `_src`, `_valid`, `busy`, `job_done`, `job_id`, `job_err`.
- Reset mid-job aborts immediately: the pending `_valid` data is discarded and no `job_done` is issued.
- Request latency: `req` seen in IDLE at edge N gives START (`gen_start` high) in cycle N+1 and RUN from N+2.
- `gen_ready` is first high in the first RUN cycle.
- Throughput is one tuple per cycle with `_ready` held high.
- Job end: `gen_done` at edge M with the output empty or draining gives `job_done` at cycle M+1 at the earliest.
- The earliest next START is 2 cycles after FINISH.
- No combinational path from `_ready` or `gen_valid` to `_valid`/`_out*`; outputs are registered. `gen_ready` is combinational from `_valid`/`_ready`/state.

## Test plan
1. **Single job:** `req`=0001. Gen 0 emits (1,2),(3,4) then done, `_ready`=1. Expect `gen_start[0]` in cycle 1, `_out` (1,2),(3,4) with `_src`=0, `job_done` with `job_id`=0 and `job_err`=0, `busy` back to 0.
2. **Round-robin:** `req`=1111 held. Each gen emits one tuple then done. Expect grant order 0,1,2,3,0; `ptr` wraps 3→0.
3. **Backpressure:** `_ready` toggles 1,0,0,1 during a 4-tuple job. Expect `gen_ready` low whenever `_valid`=1 and `_ready`=0, no tuple lost or duplicated, and `job_done` only after the last tuple is accepted.
4. **Simultaneous valid+done:** gen asserts `gen_valid` and `gen_done` in the same cycle with data (7,-7). Expect (7,-7) to be forwarded and then `job_done`.
5. **Timeout:** `TIMEOUT`=8, gen never asserts valid or done. Expect `job_done`=1 and `job_err`=1 exactly 8 RUN cycles after START, and the next requester granted afterwards.
6. **Reset mid-job:** drop `_reset_n` for one cycle while `_valid`=1 in RUN. Expect all outputs 0 the next cycle, no `job_done`, and `req`=0010 then served starting with `gen_start[1]`.
